sound_event_arbiter: RTL

SOUND_EVENT_ARBITER -- requirements
Module: sound_event_arbiter

---
 rtl/sound_event_arbiter_pkg.sv | 50 +++++
 rtl/sound_event_arbiter_tone_divider.sv | 43 ++++
 rtl/sound_event_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sound_event_arbiter_pkg.sv
// Shared pong sound definitions: source ids, FSM states, tone table and counter widths.
// Every file of the sound arbiter takes its codes and tone figures from here.
package sound_event_arbiter_pkg;

  // Source ids double as the active_id output encoding.
  typedef enum logic [1:0] {
    SrcNone   = 2'd0,
    SrcWall   = 2'd1,
    SrcPaddle = 2'd2,
    SrcScore  = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StGap  = 2'd2
  } state_e;

  // Tone table.
  localparam int unsigned WallHz   = 220;
  localparam int unsigned PaddleHz = 440;
  localparam int unsigned ScoreHz  = 880;
  localparam int unsigned WallMs   = 50;
  localparam int unsigned PaddleMs = 50;
  localparam int unsigned ScoreMs  = 200;

  // Widths cover clocks up to 100 MHz: 100e6 / (2 * 220) = 227272 half-period cycles,
  // 99999 cycles per ms, and up to 255 ms per phase.
  localparam int unsigned ToneW = 18;
  localparam int unsigned PreW  = 17;
  localparam int unsigned MsW   = 8;

  // Half-period in clock cycles, truncated.
  function automatic int unsigned half_cycles(int unsigned clk_mhz, int unsigned hz);
    return (clk_mhz * 1_000_000) / (2 * hz);
  endfunction

  // Tone length in ms for a source.
  function automatic logic [MsW-1:0] tone_ms(src_e src);
    logic [MsW-1:0] ms;
    case (src)
      SrcWall:   ms = MsW'(WallMs);
      SrcPaddle: ms = MsW'(PaddleMs);
      SrcScore:  ms = MsW'(ScoreMs);
      default:   ms = '0;
    endcase
    return ms;
  endfunction

endpackage

// File: rtl/sound_event_arbiter_tone_divider.sv
// Square-wave tone divider: load restarts at 0 with a new half-period, enable runs it,
// and the output toggles every half-period cycles. Output is held 0 when not enabled.
module sound_event_arbiter_tone_divider
  import sound_event_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [ToneW-1:0] half,
  output logic             square
);

  logic [ToneW-1:0] half_q;
  logic [ToneW-1:0] cnt_q;
  logic             square_q;

  // Half-period counter and output toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_q   <= '0;
      cnt_q    <= '0;
      square_q <= 1'b0;
    end else if (load) begin
      half_q   <= half;
      cnt_q    <= '0;
      square_q <= 1'b0;
    end else if (enable) begin
      if (cnt_q == half_q - 1'b1) begin
        cnt_q    <= '0;
        square_q <= ~square_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q    <= '0;
      square_q <= 1'b0;
    end
  end

  assign square = square_q;

endmodule

// File: rtl/sound_event_arbiter.sv
// Pong sound event arbiter: latches one-cycle sound requests, plays them one at a time by
// fixed priority (score > paddle > wall) as a square-wave tone, followed by a silent gap.
// Optional feature macro SOUND_PREEMPT_EN: a pending score request aborts a wall or paddle
// tone and starts the score tone on the next cycle without a gap.
module sound_event_arbiter
  import sound_event_arbiter_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = 100,
  parameter int unsigned GAP_MS       = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req_wall,
  input  logic       req_paddle,
  input  logic       req_score,
  output logic       SpeakerOut,
  output logic       busy,
  output logic [1:0] active_id
);

  localparam logic [PreW-1:0]  PreLast    = PreW'(CLK_FREQ_MHZ * 1000 - 1);
  localparam logic [MsW-1:0]   GapLast    = MsW'(GAP_MS - 1);
  localparam logic [ToneW-1:0] HalfWall   = ToneW'(half_cycles(CLK_FREQ_MHZ, WallHz));
  localparam logic [ToneW-1:0] HalfPaddle = ToneW'(half_cycles(CLK_FREQ_MHZ, PaddleHz));
  localparam logic [ToneW-1:0] HalfScore  = ToneW'(half_cycles(CLK_FREQ_MHZ, ScoreHz));

  state_e           state_q;
  src_e             act_q;
  logic             busy_q;
  logic [2:0]       pend_q;   // {score, paddle, wall}
  logic [PreW-1:0]  pre_q;
  logic [MsW-1:0]   ms_q;

  src_e             grant;
  logic [2:0]       grant_oh;
  logic [2:0]       req_vec;
  logic [2:0]       pend_d;
  logic [MsW-1:0]   ms_last;
  logic [ToneW-1:0] half_sel;
  logic             ms_tick;
  logic             play_done;
  logic             gap_done;
  logic             preempt;
  logic             start_play;
  logic             tone_en;

  assign req_vec = {req_score, req_paddle, req_wall};

  // Grant selection, phase-end detection and pending-flag next state.
  always_comb begin
    grant    = SrcNone;
    grant_oh = 3'b000;
    if (pend_q[2]) begin
      grant    = SrcScore;
      grant_oh = 3'b100;
    end else if (pend_q[1]) begin
      grant    = SrcPaddle;
      grant_oh = 3'b010;
    end else if (pend_q[0]) begin
      grant    = SrcWall;
      grant_oh = 3'b001;
    end

    ms_last   = tone_ms(act_q) - 1'b1;
    ms_tick   = (pre_q == PreLast);
    play_done = (state_q == StPlay) && ms_tick && (ms_q == ms_last);
    gap_done  = (state_q == StGap) && ms_tick && (ms_q == GapLast);

`ifdef SOUND_PREEMPT_EN
    preempt = (state_q == StPlay) && (act_q != SrcScore) && pend_q[2];
`else
    preempt = 1'b0;
`endif

    start_play = ((state_q == StIdle) && (pend_q != 3'b000)) || preempt;
    tone_en    = start_play || ((state_q == StPlay) && !play_done);

    // Set is applied after clear so a request landing on the grant edge is kept.
    pend_d = (pend_q & ~(start_play ? grant_oh : 3'b000)) | req_vec;

    case (grant)
      SrcWall:   half_sel = HalfWall;
      SrcPaddle: half_sel = HalfPaddle;
      SrcScore:  half_sel = HalfScore;
      default:   half_sel = '0;
    endcase
  end

  // Arbiter FSM with pending flags, registered outputs and the ms prescaler.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      act_q   <= SrcNone;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
    end else begin
      pend_q <= pend_d;
      if (start_play) begin
        state_q <= StPlay;
        act_q   <= grant;
        busy_q  <= 1'b1;
        pre_q   <= '0;
        ms_q    <= '0;
      end else if (play_done) begin
        state_q <= StGap;
        act_q   <= SrcNone;
        pre_q   <= '0;
        ms_q    <= '0;
      end else if (gap_done) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
        pre_q   <= '0;
        ms_q    <= '0;
      end else if (state_q != StIdle) begin
        if (ms_tick) begin
          pre_q <= '0;
          ms_q  <= ms_q + 1'b1;
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

  sound_event_arbiter_tone_divider tone_divider (
    .clk    (CLK),
    .reset  (RESET),
    .load   (start_play),
    .enable (tone_en),
    .half   (half_sel),
    .square (SpeakerOut)
  );

  assign busy      = busy_q;
  assign active_id = act_q;

endmodule
